// File: rtl/touch_paint_vram_writer.sv
// ---------------------------------------------------------------------------
// touch_paint_vram_writer
//
// Sole writer of the ILI9341 frame-buffer VRAM. After reset, and whenever a
// clear is requested, it sweeps the whole VRAM with CLEAR_COLOR. Between
// sweeps it watches the FT6206 touch stream. For every new touch point it
// stamps a BRUSH x BRUSH square of the brush colour. The square is centred on
// the touch point and clamped so that it stays fully on screen. The display
// controller scans the VRAM through its own read port, so this block never
// waits on it.
//
// Ports
//   clk           system clock
//   rstb          synchronous active-low reset
//   ena           clock enable; when low all state holds and nothing is written
//   touch         current touch event {valid, x[8:0], y[8:0]}
//   color         brush colour (RGB565), captured when a stamp starts
//   clear_req     full-screen clear request (level or pulse)
//   vram_wr_ena   VRAM write strobe
//   vram_wr_addr  VRAM write address, y*DISPLAY_WIDTH + x
//   vram_wr_data  VRAM write data (RGB565)
//   busy          high while a clear sweep or a stamp is in progress
// ---------------------------------------------------------------------------

package touch_paint_pkg;

    // One sample of the touch controller. The coordinates are raw: they may
    // lie beyond the visible area.
    typedef struct packed {
        logic       valid;
        logic [8:0] x;
        logic [8:0] y;
    } touch_t;

    typedef logic [15:0] ILI9341_color_t;

endpackage : touch_paint_pkg

module touch_paint_vram_writer
    import touch_paint_pkg::*;
#(
    parameter int             DISPLAY_WIDTH  = 240,
    parameter int             DISPLAY_HEIGHT = 320,
    parameter int             VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int             BRUSH          = 4,
    parameter ILI9341_color_t CLEAR_COLOR    = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      ena,
    input  touch_t                    touch,
    input  ILI9341_color_t            color,
    input  logic                      clear_req,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output ILI9341_color_t            vram_wr_data,
    output logic                      busy
);

    localparam int            AW        = $clog2(VRAM_L);
    localparam int            BW        = $clog2(BRUSH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(VRAM_L - 1);
    localparam logic [BW-1:0] LAST_B    = BW'(BRUSH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PAINT = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Brush origin on one axis. The left (or top) edge of the square is the
    // raw coordinate minus half a brush. That edge is clamped to the range
    // [0, span-BRUSH], so a stamp never leaves the screen and never wraps
    // into the next row. The arithmetic is signed and 11 bits wide, so a raw
    // coordinate near 0 goes negative and is clamped up to 0. A raw
    // coordinate beyond the panel clamps to the far edge.
    // -----------------------------------------------------------------------
    function automatic logic [8:0] brush_origin(input logic [8:0] raw,
                                                input int         span);
        logic signed [10:0] origin;
        logic signed [10:0] limit;
        origin = $signed({2'b00, raw}) - $signed(11'(BRUSH / 2));
        limit  = $signed(11'(span - BRUSH));
        if (origin < 11'sd0) begin
            return 9'd0;
        end else if (origin > limit) begin
            return 9'(limit);
        end else begin
            return 9'(origin);
        end
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t         state,      state_nx;
    logic [AW-1:0]  clr_cnt,    clr_cnt_nx;
    logic [BW-1:0]  bx,         bx_nx;
    logic [BW-1:0]  by,         by_nx;
    logic [8:0]     ox,         ox_nx;
    logic [8:0]     oy,         oy_nx;
    logic [8:0]     last_x,     last_x_nx;
    logic [8:0]     last_y,     last_y_nx;
    logic           last_valid, last_valid_nx;
    logic           pending,    pending_nx;
    ILI9341_color_t color_q,    color_nx;

    // A touch is new when nothing has been stamped since the last clear or
    // the last release, or when the raw point has moved. The comparison uses
    // the raw coordinates, not the clamped ones. A finger sliding off-screen
    // therefore keeps stamping at the clamped edge.
    logic new_touch;
    assign new_touch = touch.valid &&
                       (!last_valid || (touch.x != last_x) || (touch.y != last_y));

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold value before any branch, so no
        // path leaves one unassigned and no latch is inferred.
        state_nx      = state;
        clr_cnt_nx    = clr_cnt;
        bx_nx         = bx;
        by_nx         = by;
        ox_nx         = ox;
        oy_nx         = oy;
        last_x_nx     = last_x;
        last_y_nx     = last_y;
        last_valid_nx = last_valid;
        color_nx      = color_q;
        // A request is remembered in every state and even while ena is low.
        // Only S_IDLE consumes it.
        pending_nx    = pending | clear_req;

        if (ena) begin
            unique case (state)
                S_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt_nx    = '0;
                        last_valid_nx = 1'b0;
                        state_nx      = S_IDLE;
                    end else begin
                        clr_cnt_nx = clr_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (clear_req || pending) begin
                        // A clear wins over a touch that arrives on the same cycle.
                        pending_nx = 1'b0;
                        state_nx   = S_CLEAR;
                    end else if (new_touch) begin
                        color_nx      = color;
                        ox_nx         = brush_origin(touch.x, DISPLAY_WIDTH);
                        oy_nx         = brush_origin(touch.y, DISPLAY_HEIGHT);
                        last_x_nx     = touch.x;
                        last_y_nx     = touch.y;
                        last_valid_nx = 1'b1;
                        bx_nx         = '0;
                        by_nx         = '0;
                        state_nx      = S_PAINT;
                    end else if (!touch.valid) begin
                        // Lifting the finger lets the same point stamp again.
                        last_valid_nx = 1'b0;
                    end
                end

                S_PAINT: begin
                    // Row-major walk over the brush square. Touch input is
                    // ignored until the square is finished.
                    if (bx == LAST_B) begin
                        bx_nx = '0;
                        if (by == LAST_B) begin
                            by_nx    = '0;
                            state_nx = S_IDLE;
                        end else begin
                            by_nx = by + 1'b1;
                        end
                    end else begin
                        bx_nx = bx + 1'b1;
                    end
                end

                default: begin
                    state_nx = S_CLEAR;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: every flop is updated with non-blocking assignments, so each
        // register samples the values from before the clock edge, regardless
        // of statement order.
        if (!rstb) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            bx         <= '0;
            by         <= '0;
            ox         <= '0;
            oy         <= '0;
            last_x     <= '0;
            last_y     <= '0;
            last_valid <= 1'b0;
            pending    <= 1'b0;
            color_q    <= CLEAR_COLOR;
        end else begin
            state      <= state_nx;
            clr_cnt    <= clr_cnt_nx;
            bx         <= bx_nx;
            by         <= by_nx;
            ox         <= ox_nx;
            oy         <= oy_nx;
            last_x     <= last_x_nx;
            last_y     <= last_y_nx;
            last_valid <= last_valid_nx;
            pending    <= pending_nx;
            color_q    <= color_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Write port. The outputs are purely combinational from the registers, so
    // the first write appears in the cycle right after the state change.
    // -----------------------------------------------------------------------
    logic [AW-1:0] paint_row;
    logic [AW-1:0] paint_col;
    logic [AW-1:0] paint_addr;

    assign paint_row  = AW'(oy) + AW'(by);
    assign paint_col  = AW'(ox) + AW'(bx);
    assign paint_addr = paint_row * AW'(DISPLAY_WIDTH) + paint_col;

    always_comb begin
        vram_wr_ena  = 1'b0;
        vram_wr_addr = '0;
        vram_wr_data = CLEAR_COLOR;
        busy         = 1'b0;
        unique case (state)
            S_CLEAR: begin
                busy         = 1'b1;
                vram_wr_ena  = ena;
                vram_wr_addr = clr_cnt;
                vram_wr_data = CLEAR_COLOR;
            end
            S_PAINT: begin
                busy         = 1'b1;
                vram_wr_ena  = ena;
                vram_wr_addr = paint_addr;
                vram_wr_data = color_q;
            end
            default: begin
            end
        endcase
    end

endmodule : touch_paint_vram_writer

// File: tb/tb_touch_paint_vram_writer.sv
// ---------------------------------------------------------------------------
// Bench for touch_paint_vram_writer.
//
// Two instances run side by side on the same clock:
//   dut_a  default 240x320 panel, 4-pixel brush, black clear colour
//   dut_b  20x16 panel, 6-pixel brush, clear colour 16'h1234
// dut_b keeps the repeated full sweeps short.
//
// The model is a queue of expected (addr, data) writes for each instance.
// The stimulus pushes whole sweeps and whole stamps onto it, and the stamp
// geometry is worked out with plain integer arithmetic. A negedge compare
// process pops one entry for every observed write.
// ---------------------------------------------------------------------------
module tb_touch_paint_vram_writer;
    import touch_paint_pkg::*;

    localparam int             W_A  = 240;
    localparam int             H_A  = 320;
    localparam int             BR_A = 4;
    localparam int             L_A  = W_A * H_A;
    localparam ILI9341_color_t CC_A = 16'h0000;

    localparam int             W_B  = 20;
    localparam int             H_B  = 16;
    localparam int             BR_B = 6;
    localparam int             L_B  = W_B * H_B;
    localparam ILI9341_color_t CC_B = 16'h1234;

    typedef struct {
        int             addr;
        ILI9341_color_t data;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic           rstb_a, ena_a, clear_req_a;
    touch_t         touch_a;
    ILI9341_color_t color_a;
    logic           we_a, busy_a;
    logic [16:0]    addr_a;
    ILI9341_color_t data_a;

    // Instance B signals
    logic           rstb_b, ena_b, clear_req_b;
    touch_t         touch_b;
    ILI9341_color_t color_b;
    logic           we_b, busy_b;
    logic [8:0]     addr_b;
    ILI9341_color_t data_b;

    touch_paint_vram_writer dut_a (
        .clk          (clk),
        .rstb         (rstb_a),
        .ena          (ena_a),
        .touch        (touch_a),
        .color        (color_a),
        .clear_req    (clear_req_a),
        .vram_wr_ena  (we_a),
        .vram_wr_addr (addr_a),
        .vram_wr_data (data_a),
        .busy         (busy_a)
    );

    touch_paint_vram_writer #(
        .DISPLAY_WIDTH  (W_B),
        .DISPLAY_HEIGHT (H_B),
        .BRUSH          (BR_B),
        .CLEAR_COLOR    (CC_B)
    ) dut_b (
        .clk          (clk),
        .rstb         (rstb_b),
        .ena          (ena_b),
        .touch        (touch_b),
        .color        (color_b),
        .clear_req    (clear_req_b),
        .vram_wr_ena  (we_b),
        .vram_wr_addr (addr_b),
        .vram_wr_data (data_b),
        .busy         (busy_b)
    );

    int  checks   = 0;
    int  errors   = 0;
    int  wr_cnt_a = 0;
    int  wr_cnt_b = 0;
    wr_t exp_a[$];
    wr_t exp_b[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic touch_t tp(input bit v, input int x, input int y);
        touch_t t;
        t.valid = v;
        t.x     = 9'(x);
        t.y     = 9'(y);
        return t;
    endfunction

    // -------------------------------------------------------------- model --
    task automatic push_sweep(input bit b);
        wr_t e;
        for (int i = 0; i < (b ? L_B : L_A); i++) begin
            e.addr = i;
            e.data = b ? CC_B : CC_A;
            if (b) exp_b.push_back(e);
            else   exp_a.push_back(e);
        end
    endtask

    task automatic push_stamp(input bit b, input int x, input int y,
                              input ILI9341_color_t c);
        int  w  = b ? W_B  : W_A;
        int  h  = b ? H_B  : H_A;
        int  br = b ? BR_B : BR_A;
        int  ox = x - br / 2;
        int  oy = y - br / 2;
        wr_t e;
        if (ox > w - br) ox = w - br;
        if (ox < 0)      ox = 0;
        if (oy > h - br) oy = h - br;
        if (oy < 0)      oy = 0;
        for (int r = 0; r < br; r++) begin
            for (int c2 = 0; c2 < br; c2++) begin
                e.addr = (oy + r) * w + ox + c2;
                e.data = c;
                if (b) exp_b.push_back(e);
                else   exp_a.push_back(e);
            end
        end
    endtask

    // ------------------------------------------------------------ compare --
    always @(negedge clk) begin
        wr_t e;
        if (rstb_a === 1'b1) begin
            check("a_wr_ena_rule", we_a, busy_a & ena_a);
            if (we_a) begin
                wr_cnt_a++;
                check("a_write_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    check("a_addr", addr_a, e.addr);
                    check("a_data", data_a, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (rstb_b === 1'b1) begin
            check("b_wr_ena_rule", we_b, busy_b & ena_b);
            if (we_b) begin
                wr_cnt_b++;
                check("b_write_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    e = exp_b.pop_front();
                    check("b_addr", addr_b, e.addr);
                    check("b_data", data_b, e.data);
                end
            end
        end
    end

    // -------------------------------------------------------------- helpers --
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_write(input bit b, input int target, input int budget,
                              input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((b ? we_b : we_a) &&
                     ((b ? int'(addr_b) : int'(addr_a)) == target)) && n < budget);
        check(name, n < budget, 1);
    endtask

    task automatic drain(input bit b, input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((b ? exp_b.size() : exp_a.size()) != 0 ||
                    (b ? busy_b : busy_a)) && n < budget);
        check({name, "_done"}, n < budget, 1);
    endtask

    // ---------------------------------------------------- instance A tests --
    task automatic run_a();
        int base;
        rstb_a = 1'b0; ena_a = 1'b1; clear_req_a = 1'b0;
        touch_a = tp(0, 0, 0); color_a = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        check("a_reset_busy", busy_a, 1);
        check("a_reset_addr", addr_a, 0);
        step();
        push_sweep(0);
        rstb_a = 1'b1;

        // Full sweep; busy drops on the cycle after the last address.
        wait_write(0, L_A - 1, L_A + 100, "a_sweep_end");
        @(negedge clk);
        check("a_busy_fall", busy_a, 0);
        check("a_sweep_count", wr_cnt_a, 76800);
        drain(0, 10, "a_sweep");
        repeat (20) @(negedge clk);
        check("a_quiet_count", wr_cnt_a, 76800);

        // Centred stamp, one-cycle latency from the touch sample.
        step();
        push_stamp(0, 100, 200, 16'hF81F);
        check("a_model_centre_first", exp_a[0].addr, 47618);
        check("a_model_centre_last", exp_a[15].addr, 48341);
        touch_a = tp(1, 100, 200); color_a = 16'hF81F;
        @(posedge clk);
        @(negedge clk);
        check("a_latency_we", we_a, 1);
        check("a_first_addr", addr_a, 47618);
        check("a_first_data", data_a, 16'hF81F);
        drain(0, 100, "a_centre");

        // Top-left corner. The colour changes mid-stamp and must not leak in.
        push_stamp(0, 0, 0, 16'h07E0);
        check("a_model_tl_row1", exp_a[4].addr, 240);
        check("a_model_tl_last", exp_a[15].addr, 723);
        step();
        touch_a = tp(1, 0, 0); color_a = 16'h07E0;
        step(); step();
        color_a = 16'h1111;
        drain(0, 100, "a_top_left");

        // Bottom-right corner, then an off-panel point clamping to the same square.
        push_stamp(0, 239, 319, 16'h001F);
        check("a_model_br_first", exp_a[0].addr, 76076);
        check("a_model_br_last", exp_a[15].addr, 76799);
        step();
        touch_a = tp(1, 239, 319); color_a = 16'h001F;
        drain(0, 100, "a_bottom_right");
        push_stamp(0, 300, 400, 16'hFFE0);
        check("a_model_off_first", exp_a[0].addr, 76076);
        step();
        touch_a = tp(1, 300, 400); color_a = 16'hFFE0;
        drain(0, 100, "a_off_panel");

        // Dedup: a held point stamps once; moving and re-touching stamp again.
        base = wr_cnt_a;
        push_stamp(0, 50, 50, 16'h7BEF);
        step();
        touch_a = tp(1, 50, 50); color_a = 16'h7BEF;
        repeat (100) @(negedge clk);
        drain(0, 20, "a_hold");
        check("a_hold_count", wr_cnt_a - base, 16);

        base = wr_cnt_a;
        push_stamp(0, 51, 50, 16'h7BEF);
        step();
        touch_a = tp(1, 51, 50);
        drain(0, 100, "a_move");
        check("a_move_count", wr_cnt_a - base, 16);

        base = wr_cnt_a;
        step();
        touch_a = tp(0, 51, 50);
        step();
        push_stamp(0, 51, 50, 16'h7BEF);
        touch_a = tp(1, 51, 50);
        drain(0, 100, "a_retouch");
        check("a_retouch_count", wr_cnt_a - base, 16);
        step();
        touch_a = tp(0, 0, 0);
        repeat (10) @(negedge clk);
    endtask

    // ---------------------------------------------------- instance B tests --
    task automatic run_b();
        int base;
        rstb_b = 1'b0; ena_b = 1'b1; clear_req_b = 1'b0;
        touch_b = tp(0, 0, 0); color_b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        check("b_reset_busy", busy_b, 1);
        step();
        push_sweep(1);
        rstb_b = 1'b1;
        drain(1, L_B + 20, "b_sweep");
        check("b_sweep_count", wr_cnt_b, 320);

        // Centred stamp with the wider brush.
        push_stamp(1, 10, 8, 16'h07E0);
        check("b_model_first", exp_b[0].addr, 107);
        check("b_model_last", exp_b[35].addr, 212);
        step();
        touch_b = tp(1, 10, 8); color_b = 16'h07E0;
        @(posedge clk);
        @(negedge clk);
        check("b_first_addr", addr_b, 107);
        drain(1, 100, "b_stamp");

        // A clear request on the third write lets the stamp finish, then sweeps.
        base = wr_cnt_b;
        push_stamp(1, 3, 3, 16'h001F);
        check("b_model_tl_last", exp_b[35].addr, 105);
        push_sweep(1);
        step();
        touch_b = tp(1, 3, 3); color_b = 16'h001F;
        step(); step(); step();
        clear_req_b = 1'b1;
        touch_b = tp(0, 0, 0);
        step();
        clear_req_b = 1'b0;
        drain(1, 1000, "b_pending");
        check("b_pending_count", wr_cnt_b - base, 356);

        // A clear and a new touch together in idle: a sweep only.
        base = wr_cnt_b;
        step();
        push_sweep(1);
        clear_req_b = 1'b1;
        touch_b = tp(1, 7, 7); color_b = 16'hAAAA;
        step();
        clear_req_b = 1'b0;
        touch_b = tp(0, 0, 0);
        @(negedge clk);
        check("b_prio_addr", addr_b, 0);
        check("b_prio_data", data_b, 16'h1234);
        drain(1, 1000, "b_prio");
        check("b_prio_count", wr_cnt_b - base, 320);

        // Freeze mid-sweep. A clear request while frozen queues a second sweep.
        base = wr_cnt_b;
        step();
        push_sweep(1);
        clear_req_b = 1'b1;
        step();
        clear_req_b = 1'b0;
        wait_write(1, 100, 400, "b_reach_100");
        step();
        ena_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b_frozen_we", we_b, 0);
            check("b_frozen_addr", addr_b, 101);
            clear_req_b = (i == 2);
            if (i == 2) push_sweep(1);
        end
        step();
        ena_b = 1'b1;
        @(negedge clk);
        check("b_resume_we", we_b, 1);
        check("b_resume_addr", addr_b, 101);
        drain(1, 1000, "b_freeze");
        check("b_freeze_count", wr_cnt_b - base, 640);

        // Reset mid-stamp aborts it; the first write after release is address 0.
        step();
        push_stamp(1, 15, 12, 16'hFFFF);
        touch_b = tp(1, 15, 12); color_b = 16'hFFFF;
        repeat (5) step();
        rstb_b = 1'b0;
        exp_b.delete();
        touch_b = tp(0, 0, 0);
        repeat (2) step();
        push_sweep(1);
        rstb_b = 1'b1;
        @(negedge clk);
        check("b_post_reset_we", we_b, 1);
        check("b_post_reset_addr", addr_b, 0);
        check("b_post_reset_data", data_b, 16'h1234);
        drain(1, 1000, "b_post_reset");
        repeat (10) @(negedge clk);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1);
    end

endmodule : tb_touch_paint_vram_writer
